// File: rtl/emc_ebc_pkg.sv
// Shared types and constants for the external bus controller: state encodings,
// idle bus values, wait-count width and the latched request payload.
package emc_ebc_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DATA = 2'd3
    } ebc_state_e;

    localparam logic              IDLE_PSEN_B  = 1'b1;
    localparam logic              IDLE_WEB     = 1'b1;
    localparam logic              IDLE_OEB     = 1'b1;
    localparam logic [DATA_W-1:0] IDLE_P0_EN   = 8'h00;
    localparam logic [DATA_W-1:0] IDLE_P0_A    = 8'h00;
    localparam logic [DATA_W-1:0] P0_DRIVE_ALL = 8'hFF;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
    } ebc_req_t;

endpackage

// File: rtl/emc_ebc_wait_cnt.sv
// Wait-state down-counter: loaded with N on the address cycle, counts down
// through the wait cycles and flags the last one.
module emc_ebc_wait_cnt
    import emc_ebc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              last_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              last_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= (cnt_d == WAIT_W'(1));
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/emc_ext_bus_ctrl.sv
// External memory bus controller: IDLE/ADDR/WAIT/DATA access sequencer with
// registered pad outputs. Wait states are built only when EMC_EBC_WAIT_EN is defined.
module emc_ext_bus_ctrl
    import emc_ebc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] IDLE_ADDR = 16'h0000,
    parameter int unsigned       MAX_WAIT  = 3
) (
    input  logic              ebc_clock_i,
    input  logic              ebc_reset_i,
    input  logic              ebc_req_i,
    input  logic              ebc_we_i,
    input  logic              ebc_code_i,
    input  logic [ADDR_W-1:0] ebc_addr_i,
    input  logic [DATA_W-1:0] ebc_wdata_i,
    input  logic [WAIT_W-1:0] ebc_wait_i,
    input  logic [DATA_W-1:0] ebc_p0_y_i,
    output logic              ebc_busy_o,
    output logic              ebc_ack_o,
    output logic [DATA_W-1:0] ebc_rdata_o,
    output logic [DATA_W-1:0] ebc_p0_a_o,
    output logic [DATA_W-1:0] ebc_p0_en_o,
    output logic [DATA_W-1:0] ebc_p2_a_o,
    output logic [DATA_W-1:0] ebc_p4_a_o,
    output logic              ebc_web_o,
    output logic              ebc_oeb_o,
    output logic              ebc_psen_b_o
);

    ebc_state_e        state_q, state_d;
    ebc_req_t          req_q, req_d;
    logic [DATA_W-1:0] rdata_q;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [DATA_W-1:0] p0_a_q, p0_a_d;
    logic [DATA_W-1:0] p0_en_q, p0_en_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              web_q, web_d;
    logic              oeb_q, oeb_d;
    logic              psen_b_q, psen_b_d;

`ifdef EMC_EBC_WAIT_EN
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_sat_c;
    logic              wait_last;

    assign wait_sat_c = (32'(ebc_wait_i) > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : ebc_wait_i;

    emc_ebc_wait_cnt u_wait_cnt (
        .clk_i      (ebc_clock_i),
        .rst_n_i    (ebc_reset_i),
        .load_i     (state_q == ST_ADDR),
        .load_val_i (wait_q),
        .dec_i      (state_q == ST_WAIT),
        .last_o     (wait_last)
    );
`else
    logic unused_wait;
    assign unused_wait = ^{ebc_wait_i, 32'(MAX_WAIT)};
`endif

    // Next state, request latch and next registered bus values
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
`ifdef EMC_EBC_WAIT_EN
        wait_d     = wait_q;
`endif
        busy_d     = 1'b0;
        ack_d      = 1'b0;
        p0_a_d     = IDLE_P0_A;
        p0_en_d    = IDLE_P0_EN;
        bus_addr_d = IDLE_ADDR;
        web_d      = IDLE_WEB;
        oeb_d      = IDLE_OEB;
        psen_b_d   = IDLE_PSEN_B;

        case (state_q)
            ST_IDLE: begin
                if (ebc_req_i) begin
                    // A code fetch is always a read
                    req_d   = '{addr: ebc_addr_i, wdata: ebc_wdata_i, we: ebc_we_i & ~ebc_code_i};
`ifdef EMC_EBC_WAIT_EN
                    wait_d  = wait_sat_c;
`endif
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
`ifdef EMC_EBC_WAIT_EN
                state_d = (wait_q != '0) ? ST_WAIT : ST_DATA;
`else
                state_d = ST_DATA;
`endif
            end
`ifdef EMC_EBC_WAIT_EN
            ST_WAIT: begin
                if (wait_last) begin
                    state_d = ST_DATA;
                end
            end
`endif
            ST_DATA: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_IDLE) begin
            busy_d     = 1'b1;
            bus_addr_d = req_d.addr;
            psen_b_d   = 1'b0;
            ack_d      = (state_d == ST_DATA);
            if (req_d.we) begin
                p0_en_d = P0_DRIVE_ALL;
                p0_a_d  = req_d.wdata;
                web_d   = (state_d == ST_DATA);
            end else begin
                oeb_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge ebc_clock_i) begin
        if (!ebc_reset_i) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
`ifdef EMC_EBC_WAIT_EN
            wait_q     <= '0;
`endif
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            p0_a_q     <= IDLE_P0_A;
            p0_en_q    <= IDLE_P0_EN;
            bus_addr_q <= IDLE_ADDR;
            web_q      <= IDLE_WEB;
            oeb_q      <= IDLE_OEB;
            psen_b_q   <= IDLE_PSEN_B;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
`ifdef EMC_EBC_WAIT_EN
            wait_q     <= wait_d;
`endif
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            p0_a_q     <= p0_a_d;
            p0_en_q    <= p0_en_d;
            bus_addr_q <= bus_addr_d;
            web_q      <= web_d;
            oeb_q      <= oeb_d;
            psen_b_q   <= psen_b_d;
            // RAM data is valid by the end of the data cycle
            if ((state_q == ST_DATA) && !req_q.we) begin
                rdata_q <= ebc_p0_y_i;
            end
        end
    end

    assign ebc_busy_o   = busy_q;
    assign ebc_ack_o    = ack_q;
    assign ebc_rdata_o  = rdata_q;
    assign ebc_p0_a_o   = p0_a_q;
    assign ebc_p0_en_o  = p0_en_q;
    assign ebc_p2_a_o   = bus_addr_q[15:8];
    assign ebc_p4_a_o   = bus_addr_q[7:0];
    assign ebc_web_o    = web_q;
    assign ebc_oeb_o    = oeb_q;
    assign ebc_psen_b_o = psen_b_q;

endmodule

// File: tb/tb_emc_ext_bus_ctrl.sv
// Bench for emc_ext_bus_ctrl: directed accesses against an async RAM model,
// with a queue of expected completions checked by an independent monitor.
module tb_emc_ext_bus_ctrl;

    localparam logic [15:0] TB_IDLE_ADDR = 16'hBEEF;
    localparam int          TB_MAX_WAIT  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, code;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [1:0]  wait_n;
    logic [7:0]  p0_y;
    logic        busy, ack;
    logic [7:0]  rdata, p0_a, p0_en, p2_a, p4_a;
    logic        web, oeb, psen_b;

    emc_ext_bus_ctrl #(.IDLE_ADDR(TB_IDLE_ADDR), .MAX_WAIT(TB_MAX_WAIT)) dut (
        .ebc_clock_i  (clk),
        .ebc_reset_i  (rst_n),
        .ebc_req_i    (req),
        .ebc_we_i     (we),
        .ebc_code_i   (code),
        .ebc_addr_i   (addr),
        .ebc_wdata_i  (wdata),
        .ebc_wait_i   (wait_n),
        .ebc_p0_y_i   (p0_y),
        .ebc_busy_o   (busy),
        .ebc_ack_o    (ack),
        .ebc_rdata_o  (rdata),
        .ebc_p0_a_o   (p0_a),
        .ebc_p0_en_o  (p0_en),
        .ebc_p2_a_o   (p2_a),
        .ebc_p4_a_o   (p4_a),
        .ebc_web_o    (web),
        .ebc_oeb_o    (oeb),
        .ebc_psen_b_o (psen_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Asynchronous external RAM
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (!psen_b && !web) mem[{p2_a, p4_a}] <= p0_a;
    end
    assign p0_y = (!psen_b && !oeb) ? mem[{p2_a, p4_a}] : 8'h00;

    typedef struct {
        int          ack_cyc;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  rdata;
        int          n;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] last_rd = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int n_of(input logic [1:0] w);
`ifdef EMC_EBC_WAIT_EN
        return (int'(w) > TB_MAX_WAIT) ? TB_MAX_WAIT : int'(w);
`else
        return 0;
`endif
    endfunction

    // Monitor: per-access strobe counts, completion timing and read data
    int   psen_cnt, web_cnt, oeb_cnt, en_cnt;
    logic rd_pend;
    logic [7:0] pend_rd;
    always @(negedge clk) begin
        if (!rst_n) begin
            psen_cnt = 0; web_cnt = 0; oeb_cnt = 0; en_cnt = 0; rd_pend = 1'b0;
        end else begin
            if (!psen_b)         psen_cnt++;
            if (!web)            web_cnt++;
            if (!oeb)            oeb_cnt++;
            if (p0_en == 8'hFF)  en_cnt++;
            if (rd_pend) begin
                check("rdata", 32'(rdata), 32'(pend_rd));
                check("busy_after_data", 32'(busy), 32'd0);
                check("psen_after_data", 32'(psen_b), 32'd1);
                rd_pend = 1'b0;
            end
            if (ack) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack cyc=%0d actual=1 required=0", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                    check("bus_addr", 32'({p2_a, p4_a}), 32'(mon_e.addr));
                    check("busy_in_data", 32'(busy), 32'd1);
                    check("psen_low_cycles", 32'(psen_cnt), 32'(2 + mon_e.n));
                    check("web_low_cycles", 32'(web_cnt), mon_e.we ? 32'(1 + mon_e.n) : 32'd0);
                    check("oeb_low_cycles", 32'(oeb_cnt), mon_e.we ? 32'd0 : 32'(2 + mon_e.n));
                    check("p0_en_cycles", 32'(en_cnt), mon_e.we ? 32'(2 + mon_e.n) : 32'd0);
                    rd_pend = 1'b1;
                    pend_rd = mon_e.rdata;
                end
                psen_cnt = 0; web_cnt = 0; oeb_cnt = 0; en_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_psen"}, 32'(psen_b), 32'd1);
        check({tag, "_web"}, 32'(web), 32'd1);
        check({tag, "_oeb"}, 32'(oeb), 32'd1);
        check({tag, "_p0_en"}, 32'(p0_en), 32'h00);
        check({tag, "_p0_a"}, 32'(p0_a), 32'h00);
        check({tag, "_addr"}, 32'({p2_a, p4_a}), 32'(TB_IDLE_ADDR));
        check({tag, "_rdata"}, 32'(rdata), 32'h00);
    endtask

    task automatic single(input logic i_we, input logic i_code, input logic [15:0] a,
                          input logic [7:0] wd, input logic [1:0] w, input logic [7:0] exp_rd,
                          input logic [1:0] w_after);
        int   n;
        logic is_rd;
        n     = n_of(w);
        is_rd = i_code | ~i_we;
        if (is_rd) last_rd = exp_rd;
        req = 1'b1; we = i_we; code = i_code; addr = a; wdata = wd; wait_n = w;
        q.push_back('{ack_cyc: cyc + 2 + n, we: ~is_rd, addr: a, rdata: last_rd, n: n});
        step();
        req = 1'b0; wait_n = w_after;
        repeat (n + 3) step();
    endtask

    initial begin
        int c, n, t, r;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;
        mem[16'h2000] = 8'h3C;
        mem[16'h0040] = 8'hC3;

        rst_n = 1'b0; req = 1'b0; we = 1'b0; code = 1'b0;
        addr = 16'h0000; wdata = 8'h00; wait_n = 2'd0;
        repeat (3) step();
        check_idle("reset");
        rst_n = 1'b1;
        step();

        single(1'b0, 1'b0, 16'h1234, 8'h00, 2'd0, 8'hA5, 2'd0);
        single(1'b1, 1'b0, 16'hFFFF, 8'h5A, 2'd2, 8'h00, 2'd2);
        single(1'b0, 1'b0, 16'hFFFF, 8'h00, 2'd0, 8'h5A, 2'd0);
        // wait count changes right after acceptance
        single(1'b0, 1'b0, 16'h2000, 8'h00, 2'd3, 8'h3C, 2'd0);
        // code fetch with we asserted stays a read
        single(1'b1, 1'b1, 16'h0040, 8'h77, 2'd0, 8'hC3, 2'd0);
        check_idle_between();

        // held request: three back-to-back accesses
        n = n_of(2'd1);
        t = 3 + n;
        c = cyc;
        req = 1'b1; we = 1'b0; code = 1'b0; addr = 16'h1234; wait_n = 2'd1;
        last_rd = 8'hA5;
        for (int k = 0; k < 3; k++)
            q.push_back('{ack_cyc: c + k * t + 2 + n, we: 1'b0, addr: 16'h1234, rdata: 8'hA5, n: n});
        repeat (2 * t + 1) step();
        req = 1'b0;
        repeat (t + 1) step();

        // reset mid-access aborts it; held request starts right after release
        n = n_of(2'd3);
        req = 1'b1; we = 1'b0; code = 1'b0; addr = 16'h2000; wait_n = 2'd3;
        step();
        if (n > 0) step();
        rst_n = 1'b0; addr = 16'h1234; wait_n = 2'd0;
        step();
        check_idle("abort");
        rst_n = 1'b1;
        r = cyc;
        last_rd = 8'hA5;
        q.push_back('{ack_cyc: r + 2, we: 1'b0, addr: 16'h1234, rdata: 8'hA5, n: 0});
        step();
        req = 1'b0;
        repeat (5) step();

        check("ram_code_fetch_unchanged", 32'(mem[16'h0040]), 32'h000000C3);
        check("ram_write_ffff", 32'(mem[16'hFFFF]), 32'h0000005A);
        check("pending_expectations", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic check_idle_between();
        check("between_busy", 32'(busy), 32'd0);
        check("between_psen", 32'(psen_b), 32'd1);
        check("between_addr", 32'({p2_a, p4_a}), 32'(TB_IDLE_ADDR));
        check("between_p0_en", 32'(p0_en), 32'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
